marker_seq_gen: RTL and testbench

Parametrised marker and command-word sequencer on the XCVR_CLK domain. It generates the DTC-side 16-bit 8b/10b word stream (comma idle, single/double markers, retransmission requests, deliberately corrupted sequences) for ROC link self-test. It supports burst repetition, a free-running periodic clock-marker mode, a BUSY/DONE handshake, a marker counter and a configurable-depth delayed copy of the output. It sits between the HCLK-side test control registers and the transceiver TX mux.

---
 rtl/marker_seq_gen.sv | 254 +++++++++++++++++++++++++
 tb/tb_marker_seq_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/marker_seq_gen.sv
// marker_seq_gen: DTC-side 8b/10b marker and command-word sequencer for ROC link self-test.
// Emits comma idle, bursts of (possibly corrupted) marker sequences, and periodic clock markers.
module marker_seq_gen #(
  parameter int unsigned TRAIL_COMMAS = 7,
  parameter int unsigned OUT_DELAY    = 2,
  parameter int unsigned PERIOD_W     = 16
) (
  input  logic                XCVR_CLK,
  input  logic                XCVR_RESETN,
  input  logic                START,
  input  logic [3:0]          MARKER_TYPE,
  input  logic [3:0]          SEQ_NUM,
  input  logic [7:0]          BURST_LEN,
  input  logic                PERIODIC_EN,
  input  logic [PERIOD_W-1:0] PERIOD,
  output logic                BUSY,
  output logic                DONE,
  output logic [15:0]         MARKER_COUNT,
  output logic [15:0]         DATA_TO_TX,
  output logic [1:0]          KCHAR_TO_TX,
  output logic [15:0]         DATA_TO_TX_DLY,
  output logic [1:0]          KCHAR_TO_TX_DLY
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned K_W    = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned MCNT_W = 16;

  localparam logic [WORD_W-1:0] W_COMMA   = 16'hBC3C;
  localparam logic [WORD_W-1:0] W_CLK     = 16'h1C11;
  localparam logic [WORD_W-1:0] W_CLKN    = 16'h1CEE;
  localparam logic [WORD_W-1:0] W_EVT     = 16'h1C10;
  localparam logic [WORD_W-1:0] W_EVTN    = 16'h1CEF;
  localparam logic [WORD_W-1:0] W_DLY     = 16'h1C12;
  localparam logic [WORD_W-1:0] W_DLYN    = 16'h1CED;
  localparam logic [WORD_W-1:0] W_DIAG    = 16'h1C13;
  localparam logic [WORD_W-1:0] W_DIAGN   = 16'h1CEC;
  localparam logic [WORD_W-1:0] W_TMO     = 16'h1C14;
  localparam logic [WORD_W-1:0] W_RET     = 16'h1C15;
  localparam logic [WORD_W-1:0] W_RETN    = 16'h1CEA;
  localparam logic [WORD_W-1:0] W_DCSREQ  = 16'h1C00;
  localparam logic [WORD_W-1:0] W_UNUSED  = 16'h1C20;
  localparam logic [WORD_W-1:0] W_ILLEGAL = 16'h1234;

  localparam logic [K_W-1:0] K_COMMA = 2'b11;
  localparam logic [K_W-1:0] K_CMD   = 2'b10;
  localparam logic [K_W-1:0] K_DATA  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORD  = 2'd1,
    ST_TRAIL = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    word_idx, word_idx_nxt;
  logic [CNT_W-1:0]    trail_cnt, trail_cnt_nxt;
  logic [CNT_W-1:0]    burst_cnt, burst_cnt_nxt;
  logic [3:0]          cur_type, cur_type_nxt;
  logic [3:0]          cur_seq, cur_seq_nxt;
  logic                cur_periodic, cur_periodic_nxt;
  logic [PERIOD_W-1:0] per_cnt, per_cnt_nxt;
  logic                start_meta, start_s1, start_s2;

  logic [WORD_W-1:0]   data_nxt;
  logic [K_W-1:0]      k_nxt;
  logic                busy_nxt, done_nxt;
  logic [MCNT_W-1:0]   count_nxt;

  logic [WORD_W-1:0]   seq_data [4];
  logic [K_W-1:0]      seq_k [4];
  logic [IDX_W-1:0]    seq_len;

  logic [WORD_W-1:0]   dly_data [OUT_DELAY];
  logic [K_W-1:0]      dly_k [OUT_DELAY];

  logic                start_rise_c;
  logic                per_active_c;
  logic                per_expire_c;

  assign start_rise_c = start_s1 & ~start_s2;
  assign per_active_c = PERIODIC_EN && (PERIOD != '0);
  assign per_expire_c = per_active_c && (per_cnt >= PERIOD_W'(PERIOD - PERIOD_W'(1)));

  // Word table for the latched marker type; unused slots default to comma.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      seq_data[i] = W_COMMA;
      seq_k[i]    = K_CMD;
    end
    seq_k[3] = K_COMMA;
    seq_len  = IDX_W'(1);
    case (cur_type)
      4'd0:  begin seq_data[0] = W_CLK;  seq_data[1] = W_CLKN;  seq_len = IDX_W'(2); end
      4'd1:  begin seq_data[0] = W_EVT;  seq_data[1] = W_EVTN;  seq_len = IDX_W'(2); end
      4'd2:  begin seq_data[0] = W_DLY;  seq_data[1] = W_DLYN;  seq_len = IDX_W'(2); end
      4'd3:  begin
        seq_data[0] = W_RET;
        seq_data[1] = W_RETN;
        seq_data[2] = {4{cur_seq}};
        seq_k[2]    = K_DATA;
        seq_len     = IDX_W'(3);
      end
      4'd4:  begin seq_data[0] = W_DIAG; seq_data[1] = W_DIAGN; seq_len = IDX_W'(2); end
      4'd5:  seq_data[0] = W_TMO;
      4'd6:  seq_data[0] = W_DCSREQ;
      4'd7:  seq_data[0] = W_UNUSED;
      4'd8:  seq_data[0] = W_CLK;
      4'd9:  seq_data[0] = W_EVTN;
      4'd10: seq_data[0] = W_DLY;
      4'd11: begin
        seq_data[0] = W_RET;
        seq_data[1] = W_RETN;
        seq_data[2] = {cur_seq, 4'h0, cur_seq, cur_seq};
        seq_k[2]    = K_DATA;
        seq_len     = IDX_W'(3);
      end
      4'd12: begin seq_data[0] = W_CLK;  seq_data[1] = W_EVTN;  seq_len = IDX_W'(2); end
      4'd13: begin seq_data[0] = W_EVT;  seq_data[1] = W_EVT;   seq_len = IDX_W'(2); end
      4'd14: begin seq_data[0] = W_RET;  seq_data[1] = W_RETN;  seq_len = IDX_W'(2); end
      default: seq_data[0] = W_ILLEGAL;
    endcase
  end

  // Next-state and next-output logic; outputs are registered one cycle behind the state.
  always_comb begin
    state_nxt        = state;
    word_idx_nxt     = word_idx;
    trail_cnt_nxt    = trail_cnt;
    burst_cnt_nxt    = burst_cnt;
    cur_type_nxt     = cur_type;
    cur_seq_nxt      = cur_seq;
    cur_periodic_nxt = cur_periodic;
    per_cnt_nxt      = '0;
    data_nxt         = W_COMMA;
    k_nxt            = K_COMMA;
    busy_nxt         = 1'b0;
    done_nxt         = 1'b0;
    count_nxt        = MARKER_COUNT;

    case (state)
      ST_IDLE: begin
        if (start_rise_c) begin
          state_nxt        = ST_WORD;
          word_idx_nxt     = '0;
          cur_type_nxt     = MARKER_TYPE;
          cur_seq_nxt      = SEQ_NUM;
          burst_cnt_nxt    = (BURST_LEN == '0) ? CNT_W'(1) : BURST_LEN;
          cur_periodic_nxt = 1'b0;
        end else if (per_expire_c) begin
          state_nxt        = ST_WORD;
          word_idx_nxt     = '0;
          cur_type_nxt     = 4'd0;
          burst_cnt_nxt    = CNT_W'(1);
          cur_periodic_nxt = 1'b1;
        end else if (per_active_c) begin
          per_cnt_nxt = PERIOD_W'(per_cnt + PERIOD_W'(1));
        end
      end
      ST_WORD: begin
        data_nxt = seq_data[word_idx];
        k_nxt    = seq_k[word_idx];
        busy_nxt = ~cur_periodic;
        if (word_idx == '0) begin
          count_nxt = MCNT_W'(MARKER_COUNT + MCNT_W'(1));
        end
        if (word_idx == IDX_W'(seq_len - IDX_W'(1))) begin
          state_nxt     = ST_TRAIL;
          trail_cnt_nxt = CNT_W'(TRAIL_COMMAS - 1);
        end else begin
          word_idx_nxt = IDX_W'(word_idx + IDX_W'(1));
        end
      end
      ST_TRAIL: begin
        busy_nxt = ~cur_periodic;
        if (trail_cnt == '0) begin
          if (burst_cnt == CNT_W'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = ~cur_periodic;
          end else begin
            state_nxt    = ST_WORD;
            word_idx_nxt = '0;
          end
          burst_cnt_nxt = CNT_W'(burst_cnt - CNT_W'(1));
        end else begin
          trail_cnt_nxt = CNT_W'(trail_cnt - CNT_W'(1));
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, sequencing registers, START synchroniser and registered outputs.
  always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN) begin
      state        <= ST_IDLE;
      word_idx     <= '0;
      trail_cnt    <= '0;
      burst_cnt    <= '0;
      cur_type     <= '0;
      cur_seq      <= '0;
      cur_periodic <= 1'b0;
      per_cnt      <= '0;
      start_meta   <= 1'b0;
      start_s1     <= 1'b0;
      start_s2     <= 1'b0;
      DATA_TO_TX   <= W_COMMA;
      KCHAR_TO_TX  <= K_COMMA;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      MARKER_COUNT <= '0;
    end else begin
      state        <= state_nxt;
      word_idx     <= word_idx_nxt;
      trail_cnt    <= trail_cnt_nxt;
      burst_cnt    <= burst_cnt_nxt;
      cur_type     <= cur_type_nxt;
      cur_seq      <= cur_seq_nxt;
      cur_periodic <= cur_periodic_nxt;
      per_cnt      <= per_cnt_nxt;
      start_meta   <= START;
      start_s1     <= start_meta;
      start_s2     <= start_s1;
      DATA_TO_TX   <= data_nxt;
      KCHAR_TO_TX  <= k_nxt;
      BUSY         <= busy_nxt;
      DONE         <= done_nxt;
      MARKER_COUNT <= count_nxt;
    end
  end

  // Delayed copy of the registered TX word.
  always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN) begin
      for (int i = 0; i < int'(OUT_DELAY); i++) begin
        dly_data[i] <= W_COMMA;
        dly_k[i]    <= K_COMMA;
      end
    end else begin
      dly_data[0] <= DATA_TO_TX;
      dly_k[0]    <= KCHAR_TO_TX;
      for (int i = 1; i < int'(OUT_DELAY); i++) begin
        dly_data[i] <= dly_data[i-1];
        dly_k[i]    <= dly_k[i-1];
      end
    end
  end

  assign DATA_TO_TX_DLY  = dly_data[OUT_DELAY-1];
  assign KCHAR_TO_TX_DLY = dly_k[OUT_DELAY-1];

endmodule

// File: tb/tb_marker_seq_gen.sv
// tb_marker_seq_gen: table vectors, directed corner sequences and random stimulus
// against a queue-based reference model of marker_seq_gen.
module tb_marker_seq_gen;

  localparam int TRAIL = 7;
  localparam int DLYD  = 2;
  localparam int PW    = 16;

  logic          XCVR_CLK = 1'b0;
  logic          XCVR_RESETN = 1'b0;
  logic          START = 1'b0;
  logic [3:0]    MARKER_TYPE = '0;
  logic [3:0]    SEQ_NUM = '0;
  logic [7:0]    BURST_LEN = 8'd1;
  logic          PERIODIC_EN = 1'b0;
  logic [PW-1:0] PERIOD = '0;
  logic          BUSY, DONE;
  logic [15:0]   MARKER_COUNT, DATA_TO_TX, DATA_TO_TX_DLY;
  logic [1:0]    KCHAR_TO_TX, KCHAR_TO_TX_DLY;

  marker_seq_gen #(.TRAIL_COMMAS(TRAIL), .OUT_DELAY(DLYD), .PERIOD_W(PW)) dut (
    .XCVR_CLK(XCVR_CLK), .XCVR_RESETN(XCVR_RESETN), .START(START),
    .MARKER_TYPE(MARKER_TYPE), .SEQ_NUM(SEQ_NUM), .BURST_LEN(BURST_LEN),
    .PERIODIC_EN(PERIODIC_EN), .PERIOD(PERIOD), .BUSY(BUSY), .DONE(DONE),
    .MARKER_COUNT(MARKER_COUNT), .DATA_TO_TX(DATA_TO_TX), .KCHAR_TO_TX(KCHAR_TO_TX),
    .DATA_TO_TX_DLY(DATA_TO_TX_DLY), .KCHAR_TO_TX_DLY(KCHAR_TO_TX_DLY)
  );

  always #5 XCVR_CLK = ~XCVR_CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        busy;
    logic        done;
    logic        first;
  } ent_t;

  ent_t        mq[$];
  bit          m_meta = 0, m_s1 = 0, m_s2 = 0;
  int          m_idle = 0;
  logic [17:0] hist [DLYD];
  logic [15:0] exp_data = 16'hBC3C;
  logic [1:0]  exp_k = 2'b11;
  logic [17:0] exp_dly = {2'b11, 16'hBC3C};
  logic        exp_busy = 1'b0, exp_done = 1'b0;
  logic [15:0] exp_count = '0;

  function automatic logic [17:0] cmd(input logic [15:0] d);
    return {2'b10, d};
  endfunction

  task automatic push_marker(input logic [3:0] typ, input logic [3:0] sn,
                             input logic [7:0] blen, input bit per);
    logic [17:0] w[$];
    ent_t e;
    int reps;
    case (typ)
      4'd0:  w = '{cmd(16'h1C11), cmd(16'h1CEE)};
      4'd1:  w = '{cmd(16'h1C10), cmd(16'h1CEF)};
      4'd2:  w = '{cmd(16'h1C12), cmd(16'h1CED)};
      4'd3:  w = '{cmd(16'h1C15), cmd(16'h1CEA), {2'b00, sn, sn, sn, sn}};
      4'd4:  w = '{cmd(16'h1C13), cmd(16'h1CEC)};
      4'd5:  w = '{cmd(16'h1C14)};
      4'd6:  w = '{cmd(16'h1C00)};
      4'd7:  w = '{cmd(16'h1C20)};
      4'd8:  w = '{cmd(16'h1C11)};
      4'd9:  w = '{cmd(16'h1CEF)};
      4'd10: w = '{cmd(16'h1C12)};
      4'd11: w = '{cmd(16'h1C15), cmd(16'h1CEA), {2'b00, sn, 4'h0, sn, sn}};
      4'd12: w = '{cmd(16'h1C11), cmd(16'h1CEF)};
      4'd13: w = '{cmd(16'h1C10), cmd(16'h1C10)};
      4'd14: w = '{cmd(16'h1C15), cmd(16'h1CEA)};
      default: w = '{cmd(16'h1234)};
    endcase
    reps = (blen == 8'd0) ? 1 : int'(blen);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < w.size(); i++) begin
        e.d = w[i][15:0]; e.k = w[i][17:16];
        e.busy = !per; e.done = 1'b0; e.first = (i == 0);
        mq.push_back(e);
      end
      for (int c = 0; c < TRAIL; c++) begin
        e.d = 16'hBC3C; e.k = 2'b11; e.busy = !per; e.first = 1'b0;
        e.done = !per && (r == reps - 1) && (c == TRAIL - 1);
        mq.push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_meta = 0; m_s1 = 0; m_s2 = 0; m_idle = 0;
    for (int i = 0; i < DLYD; i++) hist[i] = {2'b11, 16'hBC3C};
    exp_data = 16'hBC3C; exp_k = 2'b11; exp_dly = {2'b11, 16'hBC3C};
    exp_busy = 0; exp_done = 0; exp_count = '0;
  endtask

  task automatic model_step();
    bit rise;
    ent_t e;
    rise = m_s1 && !m_s2;
    m_s2 = m_s1; m_s1 = m_meta; m_meta = START;
    for (int i = DLYD - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {exp_k, exp_data};
    exp_dly = hist[DLYD-1];
    if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_data = e.d; exp_k = e.k; exp_busy = e.busy; exp_done = e.done;
      if (e.first) exp_count = exp_count + 16'd1;
      m_idle = 0;
    end else begin
      exp_data = 16'hBC3C; exp_k = 2'b11; exp_busy = 0; exp_done = 0;
      if (rise) begin
        push_marker(MARKER_TYPE, SEQ_NUM, BURST_LEN, 1'b0);
        m_idle = 0;
      end else if (PERIODIC_EN && PERIOD != '0) begin
        if (m_idle >= int'(PERIOD) - 1) begin
          push_marker(4'd0, 4'd0, 8'd1, 1'b1);
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end else begin
        m_idle = 0;
      end
    end
  endtask

  initial model_reset();

  always @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
    if (!XCVR_RESETN) model_reset();
    else model_step();
  end

  // Continuous comparison of every output against the model.
  always @(negedge XCVR_CLK) begin
    if (chk_en) begin
      check("model_word", {KCHAR_TO_TX, DATA_TO_TX}, {exp_k, exp_data});
      check("model_dly", {KCHAR_TO_TX_DLY, DATA_TO_TX_DLY}, exp_dly);
      check("model_busy_done", {BUSY, DONE}, {exp_busy, exp_done});
      check("model_count", MARKER_COUNT, exp_count);
    end
  end

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [3:0]  typ;
    logic [3:0]  sn;
    logic [1:0]  len;
    logic [17:0] w0, w1, w2;
  } vec_t;

  vec_t vt[$];

  task automatic wait_busy(input string name, output bit found);
    found = 0;
    for (int n = 0; n < 10; n++) begin
      if (BUSY) begin found = 1; break; end
      @(negedge XCVR_CLK);
    end
    check(name, found, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [17:0] ws[3];
    logic [15:0] c0;
    bit found;
    ws[0] = v.w0; ws[1] = v.w1; ws[2] = v.w2;
    c0 = MARKER_COUNT;
    MARKER_TYPE = v.typ; SEQ_NUM = v.sn; BURST_LEN = 8'd1;
    START = 1;
    @(negedge XCVR_CLK);
    @(negedge XCVR_CLK);
    START = 0;
    wait_busy($sformatf("vec%0d_busy", v.typ), found);
    if (found) begin
      for (int i = 0; i < int'(v.len); i++) begin
        check($sformatf("vec%0d_word%0d", v.typ, i), {KCHAR_TO_TX, DATA_TO_TX}, ws[i]);
        @(negedge XCVR_CLK);
      end
      for (int c = 0; c < TRAIL; c++) begin
        check($sformatf("vec%0d_comma%0d", v.typ, c), {KCHAR_TO_TX, DATA_TO_TX}, {2'b11, 16'hBC3C});
        check($sformatf("vec%0d_done%0d", v.typ, c), {BUSY, DONE}, {1'b1, (c == TRAIL - 1)});
        @(negedge XCVR_CLK);
      end
      check($sformatf("vec%0d_end", v.typ), {BUSY, DONE}, 2'b00);
      check($sformatf("vec%0d_count", v.typ), MARKER_COUNT, 16'(c0 + 16'd1));
    end
    repeat (3) @(negedge XCVR_CLK);
  endtask

  initial begin
    bit found, busy_seen;
    int n, bc, dc;
    logic [15:0] c0;

    vt.push_back('{4'd3,  4'hA, 2'd3, 18'h21C15, 18'h21CEA, 18'h0AAAA});
    vt.push_back('{4'd0,  4'h0, 2'd2, 18'h21C11, 18'h21CEE, 18'h0});
    vt.push_back('{4'd1,  4'h0, 2'd2, 18'h21C10, 18'h21CEF, 18'h0});
    vt.push_back('{4'd2,  4'h0, 2'd2, 18'h21C12, 18'h21CED, 18'h0});
    vt.push_back('{4'd4,  4'h0, 2'd2, 18'h21C13, 18'h21CEC, 18'h0});
    vt.push_back('{4'd5,  4'h0, 2'd1, 18'h21C14, 18'h0, 18'h0});
    vt.push_back('{4'd6,  4'h0, 2'd1, 18'h21C00, 18'h0, 18'h0});
    vt.push_back('{4'd7,  4'h0, 2'd1, 18'h21C20, 18'h0, 18'h0});
    vt.push_back('{4'd8,  4'hA, 2'd1, 18'h21C11, 18'h0, 18'h0});
    vt.push_back('{4'd9,  4'hA, 2'd1, 18'h21CEF, 18'h0, 18'h0});
    vt.push_back('{4'd10, 4'hA, 2'd1, 18'h21C12, 18'h0, 18'h0});
    vt.push_back('{4'd11, 4'hA, 2'd3, 18'h21C15, 18'h21CEA, 18'h0A0AA});
    vt.push_back('{4'd12, 4'hA, 2'd2, 18'h21C11, 18'h21CEF, 18'h0});
    vt.push_back('{4'd13, 4'hA, 2'd2, 18'h21C10, 18'h21C10, 18'h0});
    vt.push_back('{4'd14, 4'hA, 2'd2, 18'h21C15, 18'h21CEA, 18'h0});
    vt.push_back('{4'd15, 4'hA, 2'd1, 18'h21234, 18'h0, 18'h0});
    vt.push_back('{4'd11, 4'h5, 2'd3, 18'h21C15, 18'h21CEA, 18'h05055});
    vt.push_back('{4'd3,  4'h3, 2'd3, 18'h21C15, 18'h21CEA, 18'h03333});

    chk_en = 1;
    repeat (3) @(negedge XCVR_CLK);
    check("reset_word", {KCHAR_TO_TX, DATA_TO_TX}, {2'b11, 16'hBC3C});
    check("reset_status", {BUSY, DONE, MARKER_COUNT}, 18'h0);
    #2 XCVR_RESETN = 1;
    repeat (20) @(negedge XCVR_CLK);
    check("idle_word", {KCHAR_TO_TX, DATA_TO_TX, KCHAR_TO_TX_DLY, DATA_TO_TX_DLY},
          {2'b11, 16'hBC3C, 2'b11, 16'hBC3C});

    foreach (vt[i]) run_vec(vt[i]);

    // Burst of three clock markers with an ignored mid-burst START.
    c0 = MARKER_COUNT;
    MARKER_TYPE = 4'd0; BURST_LEN = 8'd3;
    START = 1;
    @(negedge XCVR_CLK); @(negedge XCVR_CLK);
    START = 0;
    wait_busy("burst_busy", found);
    check("burst_first", DATA_TO_TX, 16'h1C11);
    bc = 0; dc = 0; n = 0;
    MARKER_TYPE = 4'd5;
    while (BUSY && n < 100) begin
      bc++; if (DONE) dc++; n++;
      if (n == 10) START = 1;
      if (n == 13) START = 0;
      @(negedge XCVR_CLK);
    end
    check("burst_cycles", bc, 27);
    check("burst_dones", dc, 1);
    check("burst_count", MARKER_COUNT, 16'(c0 + 16'd3));
    busy_seen = 0;
    repeat (12) begin @(negedge XCVR_CLK); busy_seen |= BUSY; end
    check("burst_not_queued", busy_seen, 1'b0);

    // Periodic clock markers.
    PERIOD = 16'd40; PERIODIC_EN = 1; MARKER_TYPE = 4'd1; BURST_LEN = 8'd1;
    found = 0; busy_seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (DATA_TO_TX == 16'h1C11) begin found = 1; break; end
      @(negedge XCVR_CLK);
    end
    check("per_first", found, 1'b1);
    n = 0; found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge XCVR_CLK); n++; busy_seen |= BUSY;
      if (n == 1) check("per_clkn", DATA_TO_TX, 16'h1CEE);
      if (DATA_TO_TX == 16'h1C11) begin found = 1; break; end
    end
    check("per_spacing", n, 49);
    check("per_busy_low", busy_seen, 1'b0);

    // START landing in the periodic expiry cycle.
    c0 = MARKER_COUNT;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      if (mq.size() == 0 && m_idle == int'(PERIOD) - 3) begin found = 1; break; end
      @(negedge XCVR_CLK);
    end
    check("race_align", found, 1'b1);
    START = 1;
    @(negedge XCVR_CLK); @(negedge XCVR_CLK);
    START = 0;
    wait_busy("race_busy", found);
    check("race_word", {KCHAR_TO_TX, DATA_TO_TX}, {2'b10, 16'h1C10});
    check("race_count", MARKER_COUNT, 16'(c0 + 16'd1));
    PERIODIC_EN = 0;
    repeat (15) @(negedge XCVR_CLK);

    // Reset during the Retn word.
    MARKER_TYPE = 4'd3; SEQ_NUM = 4'h6;
    START = 1;
    @(negedge XCVR_CLK); @(negedge XCVR_CLK);
    START = 0;
    found = 0;
    for (int k = 0; k < 12; k++) begin
      if (DATA_TO_TX == 16'h1CEA) begin found = 1; break; end
      @(negedge XCVR_CLK);
    end
    check("rst_find_retn", found, 1'b1);
    #2 XCVR_RESETN = 0;
    #1;
    check("rst_word", {KCHAR_TO_TX, DATA_TO_TX}, {2'b11, 16'hBC3C});
    check("rst_dly", {KCHAR_TO_TX_DLY, DATA_TO_TX_DLY}, {2'b11, 16'hBC3C});
    check("rst_status", {BUSY, DONE, MARKER_COUNT}, 18'h0);
    @(negedge XCVR_CLK);
    #2 XCVR_RESETN = 1;
    repeat (3) @(negedge XCVR_CLK);
    run_vec('{4'd3, 4'h6, 2'd3, 18'h21C15, 18'h21CEA, 18'h06666});

    // Random stimulus against the model, with occasional resets.
    for (int it = 0; it < 400; it++) begin
      MARKER_TYPE = 4'($urandom);
      SEQ_NUM     = 4'($urandom);
      BURST_LEN   = 8'($urandom_range(0, 3));
      PERIODIC_EN = 1'($urandom_range(0, 1));
      PERIOD      = PW'($urandom_range(0, 25));
      START       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        #2 XCVR_RESETN = 0;
        @(negedge XCVR_CLK);
        #2 XCVR_RESETN = 1;
      end
      repeat ($urandom_range(1, 12)) @(negedge XCVR_CLK);
    end

    START = 0; PERIODIC_EN = 0;
    repeat (60) @(negedge XCVR_CLK);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
